q4_sweep_ctrl: RTL and testbench

- Sequencer that exercises the 4-input combinational function block q4 (inputs a,b,c,d, output f) exhaustively in hardware.
- Drives all 16 input codes {a,b,c,d} = 0..15 in order and waits a programmable settle time on each code before sampling f.
- Checks each sample against ON/OFF masks; don't-care codes are skipped. Reports error count, first failing code and the captured truth table.
- Sits beside the q4 instance in the lab top level and replaces the manual stimulus bench for on-board self-test.

---
 rtl/q4_sweep_ctrl_pkg.sv | 26 ++
 rtl/q4_sweep_ctrl_settle_cnt.sv | 32 +++
 rtl/q4_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_q4_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/q4_sweep_ctrl_pkg.sv
// Shared definitions for the q4 exhaustive-sweep self-test: golden ON/OFF
// masks for the q4 function, sweep geometry and controller state encoding.
package q4_sweep_ctrl_pkg;

   localparam int unsigned Q4_NCODES = 16;
   localparam int unsigned CODE_W    = 4;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned ERR_W     = 5;
   localparam int unsigned Q4_SETTLE = 2;

   // Golden expectation: bit i set means code i must give f=1 / f=0.
   localparam logic [Q4_NCODES-1:0] Q4_ON_MASK  = 16'h058F;
   localparam logic [Q4_NCODES-1:0] Q4_OFF_MASK = 16'h7210;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } q4_state_e;

   // A code listed in both masks is treated as an ON code.
   function automatic logic q4_mismatch(input logic on, input logic off, input logic f);
      return on ? !f : (off & f);
   endfunction

endpackage

// File: rtl/q4_sweep_ctrl_settle_cnt.sv
// Settle-time counter for the q4 sweep: counts up from 0 each cycle and flags
// the cycle in which the count equals SETTLE.
//   clk, rst : clock, synchronous active-high reset
//   load     : clear the count to 0 at the next edge (has priority over counting)
//   term_c   : combinational, high while count == SETTLE
module q4_sweep_ctrl_settle_cnt
   import q4_sweep_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE = Q4_SETTLE
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic term_c
);

   logic [CNT_W-1:0] cnt;

   // Free-running up-counter, cleared on load.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign term_c = (cnt == CNT_W'(SETTLE));

endmodule

// File: rtl/q4_sweep_ctrl.sv
// Exhaustive self-test sequencer for the 4-input function block q4. Walks all
// 16 input codes, holds each for SETTLE+1 cycles, samples f on the last cycle
// and checks it against ON/OFF masks (don't-care codes are not checked).
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a sweep (only honoured in IDLE, and only without abort)
//   abort       : stop the running sweep, no done pulse
//   f_in        : f output of q4
//   abcd_out    : {a,b,c,d} driven to q4, bit3 = a
//   busy        : sweep in progress
//   done        : one-cycle pulse after a completed sweep
//   pass        : completed sweep had no mismatches; held until next start
//   err_count   : mismatching checked codes, saturating
//   fail_valid  : at least one mismatch seen
//   fail_idx    : code of the first mismatch
//   captured    : sampled f per code (bit i = code i)
module q4_sweep_ctrl
   import q4_sweep_ctrl_pkg::*;
#(
   parameter logic [Q4_NCODES-1:0] ON_MASK  = Q4_ON_MASK,
   parameter logic [Q4_NCODES-1:0] OFF_MASK = Q4_OFF_MASK,
   parameter int unsigned          SETTLE   = Q4_SETTLE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 f_in,
   output logic [CODE_W-1:0]    abcd_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_W-1:0]     err_count,
   output logic                 fail_valid,
   output logic [CODE_W-1:0]    fail_idx,
   output logic [Q4_NCODES-1:0] captured
);

   localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(Q4_NCODES - 1);

   q4_state_e         state;
   logic [CODE_W-1:0] idx;
   logic              term_c;
   logic              cnt_load_c;
   logic              mis_c;

   // Counter restarts at 0 for every code and stays cleared outside APPLY.
   assign cnt_load_c = (state != ST_APPLY) || term_c;

   q4_sweep_ctrl_settle_cnt #(
      .SETTLE (SETTLE)
   ) u_settle_cnt (
      .clk    (clk),
      .rst    (rst),
      .load   (cnt_load_c),
      .term_c (term_c)
   );

   assign mis_c    = q4_mismatch(ON_MASK[idx], OFF_MASK[idx], f_in);
   // The code index register drives q4 directly, so it holds in IDLE/DONE.
   assign abcd_out = idx;

   // Sweep FSM with registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_idx   <= '0;
         captured   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  idx        <= '0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_idx   <= '0;
                  captured   <= '0;
                  state      <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               if (abort) begin
                  // Partial results stay visible; pass was cleared at start.
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (term_c) begin
                  captured[idx] <= f_in;
                  if (mis_c) begin
                     if (err_count != '1) begin
                        err_count <= err_count + ERR_W'(1);
                     end
                     if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_idx   <= idx;
                     end
                  end
                  if (idx == LAST_CODE) begin
                     busy  <= 1'b0;
                     state <= ST_DONE;
                  end else begin
                     idx <= idx + CODE_W'(1);
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b1;
               pass  <= (err_count == '0);
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q4_sweep_ctrl.sv
// Bench for q4_sweep_ctrl: two instances (SETTLE=2 and SETTLE=0) share the
// control inputs, each sees f from a per-test truth table indexed by its own
// abcd_out. Directed vectors, hand sequences for abort/reset/start corner
// cases, then random tables with random abort/extra-start timing checked
// against an arithmetic model of a sweep.
module tb_q4_sweep_ctrl;

   localparam logic [15:0] ON_M  = 16'h058F;
   localparam logic [15:0] OFF_M = 16'h7210;

   typedef struct packed {
      logic [3:0]  abcd;
      logic        busy;
      logic        done;
      logic        pass;
      logic [4:0]  err;
      logic        fv;
      logic [3:0]  fi;
      logic [15:0] cap;
   } obs_t;

   typedef struct {
      logic [15:0] t;
      int          k;
      int          j;
      logic [4:0]  err;
      logic        fv;
      logic [3:0]  fi;
      logic [15:0] cap;
      logic        ps;
      int          dcyc;
   } vec_t;

   logic clk = 1'b0;
   logic rst, start, abort;
   logic [15:0] tbl;
   logic f2, f0;
   logic [3:0]  abcd2, abcd0, fi2, fi0;
   logic        busy2, busy0, done2, done0, pass2, pass0, fv2, fv0;
   logic [4:0]  err2, err0;
   logic [15:0] cap2, cap0;
   obs_t o2, o0;

   int total = 0;
   int errs  = 0;

   always #5 clk = ~clk;

   assign f2 = tbl[abcd2];
   assign f0 = tbl[abcd0];
   assign o2 = {abcd2, busy2, done2, pass2, err2, fv2, fi2, cap2};
   assign o0 = {abcd0, busy0, done0, pass0, err0, fv0, fi0, cap0};

   q4_sweep_ctrl #(.SETTLE(2)) u_s2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .f_in(f2),
      .abcd_out(abcd2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_valid(fv2), .fail_idx(fi2), .captured(cap2));

   q4_sweep_ctrl #(.SETTLE(0)) u_s0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .f_in(f0),
      .abcd_out(abcd0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_valid(fv0), .fail_idx(fi0), .captured(cap0));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected outcome of one sweep from the rules: code i is sampled in APPLY
   // cycle i*(S+1)+S; an abort raised in cycle k < 16*(S+1) cancels every
   // sample at or after cycle k.
   task automatic model(input int s, input logic [15:0] t, input int k,
                        output logic [4:0] err, output logic fv, output logic [3:0] fi,
                        output logic [15:0] cap, output logic ps, output logic [3:0] code,
                        output int dcyc, output int dn, output int bcnt);
      int  len;
      bit  ab;
      bit  mis;
      len = 16 * (s + 1);
      ab  = (k >= 0) && (k < len);
      err = '0; fv = 1'b0; fi = '0; cap = '0;
      for (int i = 0; i < 16; i++) begin
         if (!ab || (i * (s + 1) + s < k)) begin
            cap[i] = t[i];
            mis = ON_M[i] ? !t[i] : (OFF_M[i] && t[i]);
            if (mis) begin
               if (err != 5'd31) err = err + 5'd1;
               if (!fv) begin
                  fv = 1'b1;
                  fi = 4'(i);
               end
            end
         end
      end
      ps   = !ab && (err == 5'd0);
      code = ab ? 4'(k / (s + 1)) : 4'd15;
      dcyc = ab ? -1 : len + 1;
      dn   = ab ? 0 : 1;
      bcnt = ab ? k + 1 : len;
   endtask

   // One sweep: start in IDLE, abort raised during cycle k, extra start during
   // cycle j (negative = never). Runs a fixed 60-cycle window.
   task automatic run(input logic [15:0] t, input int k, input int j,
                      output int dc2, output int dn2, output int bc2,
                      output int dc0, output int dn0, output int bc0);
      dc2 = -1; dn2 = 0; bc2 = 0;
      dc0 = -1; dn0 = 0; bc0 = 0;
      tbl   = t;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_s2", 64'(o2), 64'(obs_t'({4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 16'd0})));
      chk("restart_s0", 64'(o0), 64'(obs_t'({4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 16'd0})));
      for (int n = 0; n < 60; n++) begin
         bc2 += int'(busy2);
         bc0 += int'(busy0);
         abort = (n == k);
         start = (n == j);
         @(posedge clk); #1;
         if (done2) begin dn2++; dc2 = n + 1; end
         if (done0) begin dn0++; dc0 = n + 1; end
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   task automatic check_model(input string tag, input int s, input obs_t o,
                              input logic [15:0] t, input int k,
                              input int dc, input int dn, input int bc);
      logic [4:0] e_err; logic e_fv; logic [3:0] e_fi; logic [15:0] e_cap;
      logic e_ps; logic [3:0] e_code; int e_dc, e_dn, e_bc;
      model(s, t, k, e_err, e_fv, e_fi, e_cap, e_ps, e_code, e_dc, e_dn, e_bc);
      chk({tag, ".err"},  64'(o.err),  64'(e_err));
      chk({tag, ".fv"},   64'(o.fv),   64'(e_fv));
      chk({tag, ".fi"},   64'(o.fi),   64'(e_fi));
      chk({tag, ".cap"},  64'(o.cap),  64'(e_cap));
      chk({tag, ".pass"}, 64'(o.pass), 64'(e_ps));
      chk({tag, ".abcd"}, 64'(o.abcd), 64'(e_code));
      chk({tag, ".busy"}, 64'(o.busy), 64'd0);
      chk({tag, ".ndone"}, 64'(dn), 64'(e_dn));
      chk({tag, ".dcyc"}, 64'(dc), 64'(e_dc));
      chk({tag, ".bcyc"}, 64'(bc), 64'(e_bc));
   endtask

   vec_t vecs[6];

   initial begin
      int dc2, dn2, bc2, dc0, dn0, bc0;
      int k, j;
      logic [15:0] t;

      vecs[0] = '{16'h058F, -1, -1, 5'd0, 1'b0, 4'd0, 16'h058F, 1'b1, 49};
      vecs[1] = '{16'h0000, -1, -1, 5'd7, 1'b1, 4'd0, 16'h0000, 1'b0, 49};
      vecs[2] = '{16'hFFFF, -1, -1, 5'd5, 1'b1, 4'd4, 16'hFFFF, 1'b0, 49};
      vecs[3] = '{16'h0DEF, -1, -1, 5'd0, 1'b0, 4'd0, 16'h0DEF, 1'b1, 49};
      vecs[4] = '{16'hFFFF, 18, 10, 5'd1, 1'b1, 4'd4, 16'h003F, 1'b0, -1};
      vecs[5] = '{16'h078F, -1,  5, 5'd1, 1'b1, 4'd9, 16'h078F, 1'b0, 49};

      rst = 1'b1; start = 1'b0; abort = 1'b0; tbl = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_s2", 64'(o2), 64'd0);
      chk("reset_s0", 64'(o0), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors: SETTLE=2 against the table, SETTLE=0 against the model.
      foreach (vecs[v]) begin
         run(vecs[v].t, vecs[v].k, vecs[v].j, dc2, dn2, bc2, dc0, dn0, bc0);
         chk($sformatf("vec%0d.err", v),  64'(err2),  64'(vecs[v].err));
         chk($sformatf("vec%0d.fv", v),   64'(fv2),   64'(vecs[v].fv));
         chk($sformatf("vec%0d.fi", v),   64'(fi2),   64'(vecs[v].fi));
         chk($sformatf("vec%0d.cap", v),  64'(cap2),  64'(vecs[v].cap));
         chk($sformatf("vec%0d.pass", v), 64'(pass2), 64'(vecs[v].ps));
         chk($sformatf("vec%0d.dcyc", v), 64'(dc2),   64'(vecs[v].dcyc));
         check_model($sformatf("vec%0d_s2", v), 2, o2, vecs[v].t, vecs[v].k, dc2, dn2, bc2);
         check_model($sformatf("vec%0d_s0", v), 0, o0, vecs[v].t, vecs[v].k, dc0, dn0, bc0);
      end

      // start together with abort in IDLE must not launch a sweep.
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle_s2", 64'(busy2), 64'd0);
      chk("start_abort_idle_s0", 64'(busy0), 64'd0);
      @(posedge clk); #1;
      chk("start_abort_idle_hold", 64'({busy2, busy0}), 64'd0);

      // Reset in the middle of a sweep at code 9 clears everything.
      tbl = 16'h0000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 60 && abcd2 != 4'd9; n++) begin
         @(posedge clk); #1;
      end
      chk("rst_reach_idx9", 64'(abcd2), 64'd9);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_s2", 64'(o2), 64'd0);
      chk("midrst_s0", 64'(o0), 64'd0);
      @(posedge clk); #1;
      chk("midrst_idle", 64'({busy2, busy0, abcd2}), 64'd0);
      run(16'h058F, -1, -1, dc2, dn2, bc2, dc0, dn0, bc0);
      check_model("after_rst_s2", 2, o2, 16'h058F, -1, dc2, dn2, bc2);
      check_model("after_rst_s0", 0, o0, 16'h058F, -1, dc0, dn0, bc0);

      // Random truth tables with random abort and ignored extra starts.
      for (int r = 0; r < 40; r++) begin
         t = 16'($urandom);
         k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 55));
         if ($urandom_range(0, 1) == 1)
            j = int'($urandom_range(0, (k >= 0 && k < 16) ? k : 16));
         else
            j = -1;
         run(t, k, j, dc2, dn2, bc2, dc0, dn0, bc0);
         check_model($sformatf("rnd%0d_s2", r), 2, o2, t, k, dc2, dn2, bc2);
         check_model($sformatf("rnd%0d_s0", r), 0, o0, t, k, dc0, dn0, bc0);
      end

      $display("test done: total=%0d bad=%0d", total, errs);
      $finish;
   end

endmodule
